wb_arbiter: RTL and testbench

- Write-back arbiter that collects completed µops from NUM_SRC execution-unit result ports.
- Buffers each port in a small per-source queue and drives the two write-back broadcast ports (writeback0/1).
- Those ports carry valid, need_to_wb and prd; the integer issue queue uses them to set operand-ready conditions. The same ports also feed the ROB and PRF write.
- Acts as the transmitter side of the issue-queue wakeup interface; applies flush filtering so squashed µops never broadcast.

---
 rtl/wb_arbiter_pkg.sv | 25 ++
 rtl/wb_arbiter_src_buffer.sv | 104 ++++++++++
 rtl/wb_arbiter.sv | 126 ++++++++++++
 tb/tb_wb_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared backend definitions: write-back entry layout and ROB age compare.
package wb_arbiter_pkg;

    localparam int PREG_W  = 6;
    localparam int ROBID_W = 7;
    localparam int DATA_W  = 64;

    typedef struct packed {
        logic               need_to_wb;
        logic [PREG_W-1:0]  prd;
        logic [ROBID_W-1:0] robid;
        logic [DATA_W-1:0]  data;
    } wb_entry_t;

    // True when rob id a is younger than rob id b. The MSB is the wrap bit;
    // when the wrap bits differ, a smaller index means a later lap.
    function automatic logic robid_younger(input logic [ROBID_W-1:0] a,
                                           input logic [ROBID_W-1:0] b);
        if (a[ROBID_W-1] == b[ROBID_W-1]) begin
            return a[ROBID_W-2:0] > b[ROBID_W-2:0];
        end
        return a[ROBID_W-2:0] < b[ROBID_W-2:0];
    endfunction

endpackage

// File: rtl/wb_arbiter_src_buffer.sv
// Per-source result FIFO with per-entry valid bits. Flushed entries stay in
// place until they reach the head, where they are skipped in the same cycle.
module wb_src_buffer
    import wb_arbiter_pkg::*;
#(
    parameter int SRC_DEPTH = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               valid_i,
    output logic               ready_o,
    input  wb_entry_t          entry_i,
    input  logic               flush_valid_i,
    input  logic [ROBID_W-1:0] flush_robid_i,
    input  logic               pop_i,
    output logic               head_valid_o,
    output wb_entry_t          head_o
);

    localparam int PTR_W = (SRC_DEPTH > 1) ? $clog2(SRC_DEPTH) : 1;
    localparam int CNT_W = $clog2(SRC_DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    function automatic ptr_t ptr_add(input ptr_t p, input int k);
        return ptr_t'((int'(p) + k) % SRC_DEPTH);
    endfunction

    wb_entry_t            mem_q [SRC_DEPTH];
    logic [SRC_DEPTH-1:0] vld_q, vld_d;
    ptr_t                 rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, head_idx;
    cnt_t                 count_q, count_d, skip, release_cnt;
    logic                 head_found, head_kill, push, store;

    // Ready depends only on the registered occupancy, never on a same-cycle pop.
    assign ready_o = count_q < cnt_t'(SRC_DEPTH);
    assign push    = valid_i && ready_o;
    assign store   = push && !(flush_valid_i && robid_younger(entry_i.robid, flush_robid_i));

    // Locate the oldest still-valid occupied entry, counting dead slots ahead of it.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        skip       = '0;
        head_found = 1'b0;
        head_idx   = rd_ptr_q;
        for (int k = 0; k < SRC_DEPTH; k++) begin
            if (!head_found && (k < int'(count_q))) begin
                if (vld_q[ptr_add(rd_ptr_q, k)]) begin
                    head_found = 1'b1;
                    head_idx   = ptr_add(rd_ptr_q, k);
                end else begin
                    skip = skip + cnt_t'(1);
                end
            end
        end
    end

    assign head_o       = mem_q[head_idx];
    assign head_kill    = flush_valid_i && robid_younger(head_o.robid, flush_robid_i);
    assign head_valid_o = head_found && !head_kill;

    // Next pointers, occupancy and valid bits: reclaim dead slots plus any pop.
    always_comb begin
        release_cnt = skip + cnt_t'(pop_i && head_valid_o);
        rd_ptr_d    = ptr_add(rd_ptr_q, int'(release_cnt));
        wr_ptr_d    = store ? ptr_add(wr_ptr_q, 1) : wr_ptr_q;
        count_d     = count_q - release_cnt + cnt_t'(store);
        vld_d       = vld_q;
        for (int j = 0; j < SRC_DEPTH; j++) begin
            if (flush_valid_i && robid_younger(mem_q[j].robid, flush_robid_i)) begin
                vld_d[j] = 1'b0;
            end
        end
        if (store) begin
            vld_d[wr_ptr_q] = 1'b1;
        end
    end

    // Control state: pointers, count and valid bits.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!reset_n) begin
            vld_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            vld_q    <= vld_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage.
    // NOTE: the payload array has no reset; the valid bits and count gate every read.
    always_ff @(posedge clock) begin
        if (store) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: buffers results per execution unit and round-robin
// picks up to two per cycle onto the registered writeback0/1 broadcast ports.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int SRC_DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_SRC-1:0]         src_valid,
    output logic [NUM_SRC-1:0]         src_ready,
    input  logic [NUM_SRC-1:0]         src_need_to_wb,
    input  logic [NUM_SRC*PREG_W-1:0]  src_prd,
    input  logic [NUM_SRC*ROBID_W-1:0] src_robid,
    input  logic [NUM_SRC*DATA_W-1:0]  src_data,
    output logic                       writeback0_valid,
    output logic                       writeback0_need_to_wb,
    output logic [PREG_W-1:0]          writeback0_prd,
    output logic [ROBID_W-1:0]         writeback0_robid,
    output logic [DATA_W-1:0]          writeback0_data,
    output logic                       writeback1_valid,
    output logic                       writeback1_need_to_wb,
    output logic [PREG_W-1:0]          writeback1_prd,
    output logic [ROBID_W-1:0]         writeback1_robid,
    output logic [DATA_W-1:0]          writeback1_data,
    input  logic                       flush_valid,
    input  logic [ROBID_W-1:0]         flush_robid
);

    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    typedef logic [SRC_W-1:0] src_t;

    function automatic src_t src_add(input src_t s, input int k);
        return src_t'((int'(s) + k) % NUM_SRC);
    endfunction

    wb_entry_t          src_entry [NUM_SRC];
    wb_entry_t          head      [NUM_SRC];
    logic [NUM_SRC-1:0] head_valid, pop;
    logic               grant0, grant1;
    src_t               grant0_idx, grant1_idx, rr_ptr_q, rr_ptr_d;
    wb_entry_t          wb0_q, wb0_d, wb1_q, wb1_d;
    logic               wb0_valid_q, wb1_valid_q;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign src_entry[g] = '{
            need_to_wb: src_need_to_wb[g],
            prd:        src_prd[g*PREG_W +: PREG_W],
            robid:      src_robid[g*ROBID_W +: ROBID_W],
            data:       src_data[g*DATA_W +: DATA_W]
        };

        wb_src_buffer #(.SRC_DEPTH(SRC_DEPTH)) u_buf (
            .clock         (clock),
            .reset_n       (reset_n),
            .valid_i       (src_valid[g]),
            .ready_o       (src_ready[g]),
            .entry_i       (src_entry[g]),
            .flush_valid_i (flush_valid),
            .flush_robid_i (flush_robid),
            .pop_i         (pop[g]),
            .head_valid_o  (head_valid[g]),
            .head_o        (head[g])
        );
    end

    // Round-robin scan from rr_ptr: first valid head to port0, second to port1.
    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        grant0_idx = '0;
        grant1_idx = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (head_valid[src_add(rr_ptr_q, k)]) begin
                if (!grant0) begin
                    grant0     = 1'b1;
                    grant0_idx = src_add(rr_ptr_q, k);
                end else if (!grant1) begin
                    grant1     = 1'b1;
                    grant1_idx = src_add(rr_ptr_q, k);
                end
            end
        end
    end

    // Pops, pointer advance and next output contents from the grants.
    always_comb begin
        pop = '0;
        if (grant0) pop[grant0_idx] = 1'b1;
        if (grant1) pop[grant1_idx] = 1'b1;
        rr_ptr_d = grant1 ? src_add(grant1_idx, 1) :
                   grant0 ? src_add(grant0_idx, 1) : rr_ptr_q;
        wb0_d    = grant0 ? head[grant0_idx] : '0;
        wb1_d    = grant1 ? head[grant1_idx] : '0;
    end

    // Round-robin pointer and the registered broadcast ports.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q    <= '0;
            wb0_valid_q <= 1'b0;
            wb1_valid_q <= 1'b0;
            wb0_q       <= '0;
            wb1_q       <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            wb0_valid_q <= grant0;
            wb1_valid_q <= grant1;
            wb0_q       <= wb0_d;
            wb1_q       <= wb1_d;
        end
    end

    assign writeback0_valid      = wb0_valid_q;
    assign writeback0_need_to_wb = wb0_q.need_to_wb;
    assign writeback0_prd        = wb0_q.prd;
    assign writeback0_robid      = wb0_q.robid;
    assign writeback0_data       = wb0_q.data;
    assign writeback1_valid      = wb1_valid_q;
    assign writeback1_need_to_wb = wb1_q.need_to_wb;
    assign writeback1_prd        = wb1_q.prd;
    assign writeback1_robid      = wb1_q.robid;
    assign writeback1_data       = wb1_q.data;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter: reset, latency, round robin, full
// buffer stall, flush filtering, head skip, need_to_wb=0 and mid-run reset.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    logic          clock;
    logic          reset_n;
    logic [3:0]    src_valid;
    logic [3:0]    src_ready;
    logic [3:0]    src_need_to_wb;
    logic [23:0]   src_prd;
    logic [27:0]   src_robid;
    logic [255:0]  src_data;
    logic          writeback0_valid, writeback0_need_to_wb;
    logic [5:0]    writeback0_prd;
    logic [6:0]    writeback0_robid;
    logic [63:0]   writeback0_data;
    logic          writeback1_valid, writeback1_need_to_wb;
    logic [5:0]    writeback1_prd;
    logic [6:0]    writeback1_robid;
    logic [63:0]   writeback1_data;
    logic          flush_valid;
    logic [6:0]    flush_robid;

    int n_checks = 0;
    int n_fails  = 0;

    // {valid, need_to_wb, prd, robid, data}
    wire [78:0] wb0_obs = {writeback0_valid, writeback0_need_to_wb, writeback0_prd,
                           writeback0_robid, writeback0_data};
    wire [78:0] wb1_obs = {writeback1_valid, writeback1_need_to_wb, writeback1_prd,
                           writeback1_robid, writeback1_data};

    wb_arbiter dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .src_valid             (src_valid),
        .src_ready             (src_ready),
        .src_need_to_wb        (src_need_to_wb),
        .src_prd               (src_prd),
        .src_robid             (src_robid),
        .src_data              (src_data),
        .writeback0_valid      (writeback0_valid),
        .writeback0_need_to_wb (writeback0_need_to_wb),
        .writeback0_prd        (writeback0_prd),
        .writeback0_robid      (writeback0_robid),
        .writeback0_data       (writeback0_data),
        .writeback1_valid      (writeback1_valid),
        .writeback1_need_to_wb (writeback1_need_to_wb),
        .writeback1_prd        (writeback1_prd),
        .writeback1_robid      (writeback1_robid),
        .writeback1_data       (writeback1_data),
        .flush_valid           (flush_valid),
        .flush_robid           (flush_robid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_src(input int i, input logic nwb, input logic [5:0] prd,
                           input logic [6:0] robid, input logic [63:0] data);
        src_valid[i]                = 1'b1;
        src_need_to_wb[i]           = nwb;
        src_prd[i*6 +: 6]           = prd;
        src_robid[i*7 +: 7]         = robid;
        src_data[i*64 +: 64]        = data;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        src_valid      = '0;
        src_need_to_wb = '0;
        src_prd        = '0;
        src_robid      = '0;
        src_data       = '0;
        flush_valid    = 1'b0;
        flush_robid    = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [78:0] exp_v;
        reset_n = 1'b0;
        flush_valid = 1'b0;
        flush_robid = '0;
        src_valid = 4'hF;
        src_need_to_wb = 4'hF;
        src_prd = 24'hFFFFFF;
        src_robid = '0;
        src_data = {4{64'h1234}};
        repeat (2) @(negedge clock);
        exp_v = '0;
        if (wb0_obs !== exp_v) begin
            $display("FAIL reset_wb0: got %h want %h", wb0_obs, exp_v); n_fails++;
        end
        n_checks++;
        if (wb1_obs !== exp_v) begin
            $display("FAIL reset_wb1: got %h want %h", wb1_obs, exp_v); n_fails++;
        end
        n_checks++;
        reset_n = 1'b1;
        src_valid = '0;
        @(negedge clock);
        if (src_ready !== 4'hF) begin
            $display("FAIL reset_ready: got %h want %h", src_ready, 4'hF); n_fails++;
        end
        n_checks++;
    endtask

    task automatic test_single();
        logic [78:0] exp_v;
        do_reset();
        set_src(0, 1'b1, 6'd12, 7'h05, 64'hABCD);
        @(negedge clock);
        src_valid = '0;
        if (writeback0_valid !== 1'b0) begin
            $display("FAIL single_early: got %b want 0", writeback0_valid); n_fails++;
        end
        n_checks++;
        @(negedge clock);
        exp_v = {1'b1, 1'b1, 6'd12, 7'h05, 64'hABCD};
        if (wb0_obs !== exp_v) begin
            $display("FAIL single_wb0: got %h want %h", wb0_obs, exp_v); n_fails++;
        end
        n_checks++;
        if (writeback1_valid !== 1'b0) begin
            $display("FAIL single_wb1_valid: got %b want 0", writeback1_valid); n_fails++;
        end
        n_checks++;
        @(negedge clock);
        if (writeback0_valid !== 1'b0) begin
            $display("FAIL single_pulse: got %b want 0", writeback0_valid); n_fails++;
        end
        n_checks++;
    endtask

    task automatic test_round_robin();
        logic [78:0] exp_v;
        do_reset();
        for (int i = 0; i < 4; i++) set_src(i, 1'b1, 6'(i + 1), 7'(8'h10 + i), 64'h100 + 64'(i));
        @(negedge clock);
        src_valid = '0;
        @(negedge clock);
        exp_v = {1'b1, 1'b1, 6'd1, 7'h10, 64'h100};
        if (wb0_obs !== exp_v) begin
            $display("FAIL rr_first_wb0: got %h want %h", wb0_obs, exp_v); n_fails++;
        end
        n_checks++;
        exp_v = {1'b1, 1'b1, 6'd2, 7'h11, 64'h101};
        if (wb1_obs !== exp_v) begin
            $display("FAIL rr_first_wb1: got %h want %h", wb1_obs, exp_v); n_fails++;
        end
        n_checks++;
        @(negedge clock);
        exp_v = {1'b1, 1'b1, 6'd3, 7'h12, 64'h102};
        if (wb0_obs !== exp_v) begin
            $display("FAIL rr_second_wb0: got %h want %h", wb0_obs, exp_v); n_fails++;
        end
        n_checks++;
        exp_v = {1'b1, 1'b1, 6'd4, 7'h13, 64'h103};
        if (wb1_obs !== exp_v) begin
            $display("FAIL rr_second_wb1: got %h want %h", wb1_obs, exp_v); n_fails++;
        end
        n_checks++;
        @(negedge clock);
        if ({writeback0_valid, writeback1_valid} !== 2'b00) begin
            $display("FAIL rr_drained: got %b want 00", {writeback0_valid, writeback1_valid}); n_fails++;
        end
        n_checks++;
        // Pointer is back at 0, so src0 must beat src3 for port0.
        set_src(3, 1'b1, 6'd7, 7'h23, 64'h203);
        set_src(0, 1'b1, 6'd8, 7'h20, 64'h200);
        @(negedge clock);
        src_valid = '0;
        @(negedge clock);
        exp_v = {1'b1, 1'b1, 6'd8, 7'h20, 64'h200};
        if (wb0_obs !== exp_v) begin
            $display("FAIL rr_ptr_wb0: got %h want %h", wb0_obs, exp_v); n_fails++;
        end
        n_checks++;
        exp_v = {1'b1, 1'b1, 6'd7, 7'h23, 64'h203};
        if (wb1_obs !== exp_v) begin
            $display("FAIL rr_ptr_wb1: got %h want %h", wb1_obs, exp_v); n_fails++;
        end
        n_checks++;
    endtask

    task automatic test_full_buffer();
        logic [78:0] exp_v;
        do_reset();
        set_src(0, 1'b1, 6'd0, 7'd0, 64'hA0);
        set_src(1, 1'b1, 6'd0, 7'd0, 64'hB0);
        set_src(2, 1'b1, 6'd0, 7'd0, 64'hC0);
        @(negedge clock);
        set_src(0, 1'b1, 6'd0, 7'd0, 64'hA1);
        set_src(1, 1'b1, 6'd0, 7'd0, 64'hB1);
        set_src(2, 1'b1, 6'd0, 7'd0, 64'hC1);
        @(negedge clock);
        exp_v = {1'b1, 1'b1, 6'd0, 7'd0, 64'hA0};
        if (wb0_obs !== exp_v) begin
            $display("FAIL full_c2_wb0: got %h want %h", wb0_obs, exp_v); n_fails++;
        end
        n_checks++;
        exp_v = {1'b1, 1'b1, 6'd0, 7'd0, 64'hB0};
        if (wb1_obs !== exp_v) begin
            $display("FAIL full_c2_wb1: got %h want %h", wb1_obs, exp_v); n_fails++;
        end
        n_checks++;
        if (src_ready !== 4'b1011) begin
            $display("FAIL full_ready_low: got %b want 1011", src_ready); n_fails++;
        end
        n_checks++;
        src_valid[0] = 1'b0;
        src_valid[1] = 1'b0;
        set_src(2, 1'b1, 6'd0, 7'd0, 64'hC2);
        @(negedge clock);
        exp_v = {1'b1, 1'b1, 6'd0, 7'd0, 64'hC0};
        if (wb0_obs !== exp_v) begin
            $display("FAIL full_c3_wb0: got %h want %h", wb0_obs, exp_v); n_fails++;
        end
        n_checks++;
        exp_v = {1'b1, 1'b1, 6'd0, 7'd0, 64'hA1};
        if (wb1_obs !== exp_v) begin
            $display("FAIL full_c3_wb1: got %h want %h", wb1_obs, exp_v); n_fails++;
        end
        n_checks++;
        if (src_ready !== 4'hF) begin
            $display("FAIL full_ready_back: got %b want 1111", src_ready); n_fails++;
        end
        n_checks++;
        @(negedge clock);
        src_valid = '0;
        exp_v = {1'b1, 1'b1, 6'd0, 7'd0, 64'hB1};
        if (wb0_obs !== exp_v) begin
            $display("FAIL full_c4_wb0: got %h want %h", wb0_obs, exp_v); n_fails++;
        end
        n_checks++;
        exp_v = {1'b1, 1'b1, 6'd0, 7'd0, 64'hC1};
        if (wb1_obs !== exp_v) begin
            $display("FAIL full_c4_wb1: got %h want %h", wb1_obs, exp_v); n_fails++;
        end
        n_checks++;
        @(negedge clock);
        exp_v = {1'b1, 1'b1, 6'd0, 7'd0, 64'hC2};
        if (wb0_obs !== exp_v || writeback1_valid !== 1'b0) begin
            $display("FAIL full_c5_stalled_beat: got %h/%b want %h/0", wb0_obs, writeback1_valid, exp_v);
            n_fails++;
        end
        n_checks++;
    endtask

    task automatic test_flush();
        logic [78:0] exp_v;
        do_reset();
        set_src(0, 1'b1, 6'd1, 7'h03, 64'h03);
        set_src(1, 1'b1, 6'd2, 7'h08, 64'h08);
        set_src(2, 1'b1, 6'd3, 7'h42, 64'h42);
        set_src(3, 1'b1, 6'd4, 7'h05, 64'h05);
        @(negedge clock);
        src_valid   = '0;
        flush_valid = 1'b1;
        flush_robid = 7'h05;
        set_src(1, 1'b1, 6'd5, 7'h0A, 64'h0A);
        if (src_ready[1] !== 1'b1) begin
            $display("FAIL flush_ready: got %b want 1", src_ready[1]); n_fails++;
        end
        n_checks++;
        @(negedge clock);
        flush_valid = 1'b0;
        src_valid   = '0;
        exp_v = {1'b1, 1'b1, 6'd1, 7'h03, 64'h03};
        if (wb0_obs !== exp_v) begin
            $display("FAIL flush_older_wb0: got %h want %h", wb0_obs, exp_v); n_fails++;
        end
        n_checks++;
        exp_v = {1'b1, 1'b1, 6'd4, 7'h05, 64'h05};
        if (wb1_obs !== exp_v) begin
            $display("FAIL flush_equal_wb1: got %h want %h", wb1_obs, exp_v); n_fails++;
        end
        n_checks++;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            if ({writeback0_valid, writeback1_valid} !== 2'b00) begin
                $display("FAIL flush_killed_cycle%0d: got %b want 00", c, {writeback0_valid, writeback1_valid});
                n_fails++;
            end
            n_checks++;
        end
    endtask

    task automatic test_head_skip();
        logic [78:0] exp_v;
        do_reset();
        set_src(0, 1'b1, 6'd9, 7'h10, 64'h10);
        @(negedge clock);
        flush_valid = 1'b1;
        flush_robid = 7'h05;
        set_src(0, 1'b1, 6'd10, 7'h02, 64'h02);
        @(negedge clock);
        flush_valid = 1'b0;
        src_valid   = '0;
        if (writeback0_valid !== 1'b0) begin
            $display("FAIL skip_masked: got %b want 0", writeback0_valid); n_fails++;
        end
        n_checks++;
        if (src_ready !== 4'b1110) begin
            $display("FAIL skip_dead_occupies: got %b want 1110", src_ready); n_fails++;
        end
        n_checks++;
        @(negedge clock);
        exp_v = {1'b1, 1'b1, 6'd10, 7'h02, 64'h02};
        if (wb0_obs !== exp_v || writeback1_valid !== 1'b0) begin
            $display("FAIL skip_no_bubble: got %h/%b want %h/0", wb0_obs, writeback1_valid, exp_v); n_fails++;
        end
        n_checks++;
        if (src_ready !== 4'hF) begin
            $display("FAIL skip_reclaimed: got %b want 1111", src_ready); n_fails++;
        end
        n_checks++;
    endtask

    task automatic test_need_to_wb();
        logic [78:0] exp_v;
        do_reset();
        set_src(3, 1'b0, 6'd0, 7'h21, 64'h5A5A);
        @(negedge clock);
        src_valid = '0;
        @(negedge clock);
        exp_v = {1'b1, 1'b0, 6'd0, 7'h21, 64'h5A5A};
        if (wb0_obs !== exp_v) begin
            $display("FAIL nwb_wb0: got %h want %h", wb0_obs, exp_v); n_fails++;
        end
        n_checks++;
        if (writeback1_valid !== 1'b0) begin
            $display("FAIL nwb_wb1_valid: got %b want 0", writeback1_valid); n_fails++;
        end
        n_checks++;
    endtask

    task automatic test_reset_midop();
        do_reset();
        set_src(0, 1'b1, 6'd1, 7'h01, 64'h77);
        set_src(1, 1'b1, 6'd2, 7'h02, 64'h88);
        @(negedge clock);
        src_valid = '0;
        reset_n   = 1'b0;
        #1;
        if ({writeback0_valid, writeback1_valid, src_ready} !== 6'b00_1111) begin
            $display("FAIL midop_async: got %b want 001111", {writeback0_valid, writeback1_valid, src_ready});
            n_fails++;
        end
        n_checks++;
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            if ({writeback0_valid, writeback1_valid} !== 2'b00) begin
                $display("FAIL midop_dropped_cycle%0d: got %b want 00", c, {writeback0_valid, writeback1_valid});
                n_fails++;
            end
            n_checks++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full_buffer();
        test_flush();
        test_head_skip();
        test_need_to_wb();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
